// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/debouncer slice.
package sync_pkg;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_STAGES          = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    // Counter must hold values up to DEBOUNCE_CYCLES-1; sized from cycles+1 so 1 still yields a 1-bit counter.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One input channel: metastability chain, stability counter, clean level and edge pulses.
module sync_debounce_channel
    import sync_pkg::*;
#(
    parameter int   STAGES          = DEF_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] sync_r;
    logic              sync_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              level_nxt_s;
    logic              rise_nxt_s;
    logic              fall_nxt_s;

    // Metastability chain; only the last stage is ever looked at.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
        end
    end

    assign sync_s = sync_r[STAGES-1];

    // Next-state for the stability counter, level and pulses.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_out;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        if (sync_s == level_out) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r >= CNT_LAST) begin
            // >= rather than == so a corrupted counter still cannot run past the terminal value.
            cnt_nxt_s   = {CNT_W{1'b0}};
            level_nxt_s = sync_s;
            rise_nxt_s  = sync_s;
            fall_nxt_s  = ~sync_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Registered counter, level and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            level_out  <= RESET_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            level_out  <= level_nxt_s;
            rise_pulse <= rise_nxt_s;
            fall_pulse <= fall_nxt_s;
        end
    end

endmodule

// File: rtl/sync_debounce_edge_chk.sv
// Property checks on the top-level outputs: pulse exclusivity and pulse/level consistency.
module sync_debounce_edge_chk #(
    parameter int CHANNELS = 4
) (
    input logic                clk,
    input logic                reset,
    input logic [CHANNELS-1:0] level_out,
    input logic [CHANNELS-1:0] rise_pulse,
    input logic [CHANNELS-1:0] fall_pulse,
    input logic                any_edge
);

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (reset)
        (rise_pulse & fall_pulse) == {CHANNELS{1'b0}});

    a_any_edge: assert property (@(posedge clk)
        any_edge == (|(rise_pulse | fall_pulse)));

    // Outside the cycle after reset, every level change is flagged by exactly the matching pulse.
    a_level_pulse: assert property (@(posedge clk) disable iff (reset)
        !$past(reset) |-> ((level_out ^ $past(level_out)) == (rise_pulse | fall_pulse))
                          && ((rise_pulse & ~level_out) == {CHANNELS{1'b0}})
                          && ((fall_pulse & level_out) == {CHANNELS{1'b0}}));

endmodule

// File: rtl/sync_debounce_edge.sv
// Multi-channel async-input entry block: per-channel sync + debounce, plus an any-edge summary.
module sync_debounce_edge
    import sync_pkg::*;
#(
    parameter int                  CHANNELS        = DEF_CHANNELS,
    parameter int                  STAGES          = DEF_STAGES,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_edge
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VALUE[i])
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .async_in   (async_in[i]),
            .level_out  (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    assign any_edge = |(rise_pulse | fall_pulse);

    sync_debounce_edge_chk #(
        .CHANNELS (CHANNELS)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_edge   (any_edge)
    );

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Scoreboard bench for sync_debounce_edge: two instances (idle-low and idle-1010).
module tb_sync_debounce_edge;

    localparam int CH  = 4;
    localparam int STG = 2;
    localparam int DEB = 4;
    localparam int LAT = STG + DEB;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] async_a, level_a, rise_a, fall_a;
    logic [CH-1:0] async_b, level_b, rise_b, fall_b;
    logic          any_a, any_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t;

    typedef struct {
        int            at;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] level;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    sync_debounce_edge #(
        .CHANNELS (CH), .STAGES (STG), .DEBOUNCE_CYCLES (DEB), .RESET_VALUE (4'b0000)
    ) dut_a (
        .clk (clk), .reset (reset), .async_in (async_a), .level_out (level_a),
        .rise_pulse (rise_a), .fall_pulse (fall_a), .any_edge (any_a)
    );

    sync_debounce_edge #(
        .CHANNELS (CH), .STAGES (STG), .DEBOUNCE_CYCLES (DEB), .RESET_VALUE (4'b1010)
    ) dut_b (
        .clk (clk), .reset (reset), .async_in (async_b), .level_out (level_b),
        .rise_pulse (rise_b), .fall_pulse (fall_b), .any_edge (any_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_a(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f, input logic [CH-1:0] l);
        exp_t e;
        e.at = at; e.rise = r; e.fall = f; e.level = l;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f, input logic [CH-1:0] l);
        exp_t e;
        e.at = at; e.rise = r; e.fall = f; e.level = l;
        q_b.push_back(e);
    endtask

    // Monitor A: every pulse cycle must match the next scheduled event; stale events count as missed.
    always @(negedge clk) begin
        if (any_a || ((rise_a | fall_a) != 4'b0000)) begin
            chk("any_edge_a", 32'(any_a), 32'(|(rise_a | fall_a)));
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_edge_a: rise=%b fall=%b cyc=%0d, none expected", rise_a, fall_a, cyc);
            end else begin
                e_a = q_a.pop_front();
                chk("edge_cyc_a", 32'(cyc), 32'(e_a.at));
                chk("rise_a", 32'(rise_a), 32'(e_a.rise));
                chk("fall_a", 32'(fall_a), 32'(e_a.fall));
                chk("level_a", 32'(level_a), 32'(e_a.level));
            end
        end
        if (q_a.size() > 0 && q_a[0].at < cyc) begin
            e_a = q_a.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_edge_a: no pulse seen, expected at cyc %0d", e_a.at);
        end
    end

    // Monitor B: same scheme for the non-zero idle instance.
    always @(negedge clk) begin
        if (any_b || ((rise_b | fall_b) != 4'b0000)) begin
            chk("any_edge_b", 32'(any_b), 32'(|(rise_b | fall_b)));
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_edge_b: rise=%b fall=%b cyc=%0d, none expected", rise_b, fall_b, cyc);
            end else begin
                e_b = q_b.pop_front();
                chk("edge_cyc_b", 32'(cyc), 32'(e_b.at));
                chk("rise_b", 32'(rise_b), 32'(e_b.rise));
                chk("fall_b", 32'(fall_b), 32'(e_b.fall));
                chk("level_b", 32'(level_b), 32'(e_b.level));
            end
        end
        if (q_b.size() > 0 && q_b[0].at < cyc) begin
            e_b = q_b.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_edge_b: no pulse seen, expected at cyc %0d", e_b.at);
        end
    end

    initial begin
        reset   = 1'b1;
        async_a = 4'b0000;
        async_b = 4'b1010;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_level_a", 32'(level_a), 32'h0);
        chk("rst_pulses_a", 32'(rise_a | fall_a), 32'h0);
        chk("rst_any_a", 32'(any_a), 32'h0);
        chk("rst_level_b", 32'(level_b), 32'hA);
        chk("rst_any_b", 32'(any_b), 32'h0);

        // 1. clean rise on ch0
        tick(2);
        t = cyc;
        async_a = 4'b0001;
        push_a(t + LAT, 4'b0001, 4'b0000, 4'b0001);
        tick(LAT - 1);
        @(negedge clk);
        chk("early_level_a0", 32'(level_a), 32'h0);
        tick(1);
        @(negedge clk);
        chk("rise_level_a0", 32'(level_a), 32'h1);
        tick(3);

        // 2. three-cycle glitch on ch1 is rejected
        async_a = 4'b0011;
        tick(3);
        async_a = 4'b0001;
        tick(8);
        @(negedge clk);
        chk("glitch_level_a", 32'(level_a), 32'h1);

        // 3. rise then fall on ch2
        tick(1);
        t = cyc;
        async_a = 4'b0101;
        push_a(t + LAT, 4'b0100, 4'b0000, 4'b0101);
        tick(8);
        t = cyc;
        async_a = 4'b0001;
        push_a(t + LAT, 4'b0000, 4'b0100, 4'b0001);
        tick(8);
        @(negedge clk);
        chk("fall_level_a2", 32'(level_a), 32'h1);

        // 4. ch3 bounces every 2 cycles, then settles high
        tick(1);
        for (int k = 0; k < 6; k++) begin
            async_a = (k % 2 == 0) ? 4'b1001 : 4'b0001;
            tick(2);
        end
        t = cyc;
        async_a = 4'b1001;
        push_a(t + LAT, 4'b1000, 4'b0000, 4'b1001);
        tick(8);
        @(negedge clk);
        chk("bounce_level_a", 32'(level_a), 32'h9);

        // 5. reset mid-count on ch0 forces a full recount
        tick(1);
        t = cyc;
        async_a = 4'b0000;
        push_a(t + LAT, 4'b0000, 4'b1001, 4'b0000);
        tick(8);
        t = cyc;
        async_a = 4'b0001;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_level_a", 32'(level_a), 32'h0);
        chk("midrst_pulses_a", 32'(rise_a | fall_a), 32'h0);
        chk("midrst_level_b", 32'(level_b), 32'hA);
        push_a(t + 5 + LAT, 4'b0001, 4'b0000, 4'b0001);
        tick(9);
        @(negedge clk);
        chk("recount_level_a", 32'(level_a), 32'h1);

        // 6. non-zero idle instance: all channels flip together
        chk("idle_level_b", 32'(level_b), 32'hA);
        tick(1);
        t = cyc;
        async_b = 4'b0101;
        push_b(t + LAT, 4'b0101, 4'b1010, 4'b0101);
        tick(8);
        @(negedge clk);
        chk("flip_level_b", 32'(level_b), 32'h5);

        tick(3);
        chk("queue_a_drained", 32'(q_a.size()), 32'h0);
        chk("queue_b_drained", 32'(q_b.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
